mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Byte-serial memory controller that arbitrates the single 8-bit memory bus between instruction fetch and the load/store buffer. It splits each request into byte transfers and assembles read bytes into a 32-bit result. It also stalls writes to the I/O region while the UART buffer is full, and aborts speculative reads on pipeline clear. It sits between fetch/loadstore_buffer and the top-level mem_* pins.

Parameters:
IO_HI, 2'b11, value of addr[17:16] that selects the I/O region.
INST_BYTES, 4, bytes per instruction fetch.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rdy  in  1  global ready; low freezes all state
clear  in  1  pipeline flush from reorder buffer
inst_valid  in  1  fetch request, held until inst_ready
inst_addr  in  32  fetch byte address
inst_ready  out  1  one-cycle pulse, inst_res valid
inst_res  out  32  fetched instruction, little-endian
data_valid  in  1  LSB request, held until data_ready
data_wr  in  1  1 = store, 0 = load
data_type  in  3  [1:0] size (00 byte, 01 half, 10 word); [2] 1 = zero-extend load
data_addr  in  32  data byte address
data_value  in  32  store data (low bytes used)
data_ready  out  1  one-cycle pulse, load result / store done
data_res  out  32  extended load result
mem_din  in  8  memory read byte (valid the cycle after its address)
mem_dout  out  8  memory write byte
mem_a  out  32  memory address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART tx buffer full

Behaviour:
- Reset (async) values: all outputs 0; state IDLE; byte counter 0; last_grant = DATA.
- States: IDLE, INST_RD, DATA_RD, DATA_WR.
- rdy low: all registers hold. mem_wr is forced to 0 so no write is duplicated.
- Arbitration in IDLE: if only one port is valid, grant it. If both are valid, grant the port not in last_grant (round-robin); last_grant is updated on each grant.
- A port whose ready output is high this cycle is ignored for arbitration this cycle, because its valid is still asserted. The other port may still be granted.
- Request fields are latched at the grant edge (edge 0). N = 1, 2 or 4 for data; N = INST_BYTES for fetch.
- Read: mem_a = addr+i, mem_wr = 0 in cycle i+1 (i = 0..N-1). Byte i is sampled from mem_din at edge i+2.
- Read completion: ready/res are registered at edge N+1 from stored bytes plus the current mem_din, so ready is high in cycle N+2 (word read: cycle 6). Return to IDLE at the same edge.
- Load extension: data_res is sign-extended from bit 8N-1 unless data_type[2] = 1, in which case it is zero-extended.
- Write: mem_a = addr+i, mem_dout = data_value[8i+7:8i], mem_wr = 1 in cycle i+1. data_ready is high in cycle N+1; return to IDLE.
- I/O write stall: if addr[17:16] == IO_HI and io_buffer_full = 1, the byte is not issued (mem_wr = 0) and the counter holds. The byte is issued in the first cycle io_buffer_full = 0.
- Idle bus: mem_a = 0, mem_wr = 0, mem_dout = 0.
- clear in INST_RD or DATA_RD: abort at that edge. Go to IDLE with no ready pulse, counter reset, and the partial result discarded.
- clear in DATA_WR: ignored, because stores are already committed; the store completes normally.
- clear in IDLE: inst_valid and data_valid are ignored at that edge. A ready pulse scheduled for that edge is suppressed.
- Address wrap past 0xFFFFFFFF is not checked; it is the requester's responsibility.

Decomposition:
- const.v: state encodings (`mc_idle, `mc_inst, `mc_dread, `mc_dwrite`); size codes; IO_HI select define.
- Single module with no sub-module. The byte-assembly/extension logic is one always block.

Test Plan:
- Word fetch 0x00000010, memory bytes 13 05 00 00 -> mem_a 0x10..0x13 in cycles 1-4; inst_ready in cycle 6 with inst_res = 0x00000513.
- LB at 0x20, byte 0x80, data_type = 000 -> data_res = 0xFFFFFF80. The same access with data_type = 100 -> 0x00000080.
- SH 0x1234ABCD to 0x100 -> mem_wr = 1 with (0x100, 0xCD) then (0x101, 0xAB); data_ready in cycle 3; byte 0x12 is never written.
- SB 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles, the write is issued on the 4th, then data_ready.
- inst_valid and data_valid asserted together from reset -> inst is granted first (last_grant = DATA); after inst_ready the data access is granted. The order alternates on repeated contention.
- clear asserted in cycle 2 of a word fetch -> no inst_ready and state IDLE. A new fetch of 0x40 issued next cycle completes correctly.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types, constants and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INST_RD = 2'd1,
    ST_DATA_RD = 2'd2,
    ST_DATA_WR = 2'd3
  } mc_state_e;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] MC_IO_HI      = 2'b11;
  localparam int         MC_INST_BYTES = 4;

  // Size code 2'b11 is not a legal request; it is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        zext);
    case (size)
      SIZE_BYTE: return zext ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SIZE_HALF: return zext ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default:   return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the 8-bit memory bus between instruction fetch and the load/store
// buffer, serialising each request into byte transfers.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | bus idle, round-robin arbitration between fetch and LSB
// ST_INST_RD | fetching INST_BYTES bytes, assembling the instruction
// ST_DATA_RD | load of 1/2/4 bytes, extended on completion
// ST_DATA_WR | store of 1/2/4 bytes, stalls on a full UART buffer
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI      = MC_IO_HI,
  parameter int         INST_BYTES = MC_INST_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        inst_valid,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic [31:0] inst_res,
  input  logic        data_valid,
  input  logic        data_wr,
  input  logic [2:0]  data_type,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_value,
  output logic        data_ready,
  output logic [31:0] data_res,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [2:0] INST_N = 3'(INST_BYTES);

  mc_state_e   state, state_next;
  grant_e      last_grant;
  logic [2:0]  cnt;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_zext;
  logic [31:0] rbuf;

  logic [2:0]  n_bytes;
  logic [2:0]  byte_idx;
  logic        inst_req, data_req;
  logic        grant_inst, grant_data;
  logic        rd_done, wr_done, abort, wr_stall;
  logic [31:0] rd_word, load_word;

  assign n_bytes  = (state == ST_INST_RD) ? INST_N : size_bytes(req_size);
  assign byte_idx = cnt - 3'd1;
  // A requester keeps valid high during its ready cycle; that must not re-grant it.
  assign inst_req = inst_valid && !inst_ready && !clear;
  assign data_req = data_valid && !data_ready && !clear;
  assign wr_stall = (req_addr[17:16] == IO_HI) && io_buffer_full;

  // Byte assembly: stored bytes plus the byte currently on mem_din, then extension.
  always_comb begin
    rd_word   = rbuf | (32'(mem_din) << {byte_idx[1:0], 3'b000});
    load_word = extend_load(rd_word, req_size, req_zext);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= ST_IDLE;
    else if (rdy) state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    rd_done    = 1'b0;
    wr_done    = 1'b0;
    abort      = 1'b0;
    mem_a      = '0;
    mem_dout   = '0;
    mem_wr     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inst_req && (!data_req || last_grant == GRANT_DATA)) begin
          grant_inst = 1'b1;
          state_next = ST_INST_RD;
        end else if (data_req) begin
          grant_data = 1'b1;
          state_next = data_wr ? ST_DATA_WR : ST_DATA_RD;
        end
      end
      ST_INST_RD, ST_DATA_RD: begin
        if (cnt < n_bytes) mem_a = req_addr + 32'(cnt);
        if (clear) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (cnt == n_bytes) begin
          rd_done    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DATA_WR: begin
        // Stores are already committed, so clear has no effect here.
        mem_a    = req_addr + 32'(cnt);
        mem_dout = 8'(req_wdata >> {cnt[1:0], 3'b000});
        mem_wr   = rdy && !wr_stall;
        if (!wr_stall && cnt == n_bytes - 3'd1) begin
          wr_done    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_DATA;
      cnt        <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_size   <= '0;
      req_zext   <= 1'b0;
      rbuf       <= '0;
      inst_ready <= 1'b0;
      inst_res   <= '0;
      data_ready <= 1'b0;
      data_res   <= '0;
    end else if (rdy) begin
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      if (grant_inst || grant_data) begin
        cnt        <= '0;
        rbuf       <= '0;
        req_addr   <= grant_inst ? inst_addr : data_addr;
        req_wdata  <= data_value;
        req_size   <= data_type[1:0];
        req_zext   <= data_type[2];
        last_grant <= grant_inst ? GRANT_INST : GRANT_DATA;
      end else if (abort) begin
        cnt  <= '0;
        rbuf <= '0;
      end else if (rd_done) begin
        cnt <= '0;
        if (state == ST_INST_RD) begin
          inst_ready <= 1'b1;
          inst_res   <= rd_word;
        end else begin
          data_ready <= 1'b1;
          data_res   <= load_word;
        end
      end else if (state == ST_INST_RD || state == ST_DATA_RD) begin
        if (cnt != 3'd0) rbuf <= rd_word;
        cnt <= cnt + 3'd1;
      end else if (wr_done) begin
        cnt        <= '0;
        data_ready <= 1'b1;
      end else if (state == ST_DATA_WR && !wr_stall) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of single transactions plus hand-written
// sequences for contention, I/O stall and pipeline clear.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_res;
  logic        data_valid;
  logic        data_wr;
  logic [2:0]  data_type;
  logic [31:0] data_addr;
  logic [31:0] data_value;
  logic        data_ready;
  logic [31:0] data_res;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;

  logic [7:0]  mem_model [logic [31:0]];
  logic [31:0] a_prev = '0;

  typedef struct {
    string       name;
    logic        is_inst;
    logic        wr;
    logic [2:0]  dtype;
    logic [31:0] addr;
    logic [31:0] value;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .inst_valid(inst_valid), .inst_addr(inst_addr),
    .inst_ready(inst_ready), .inst_res(inst_res),
    .data_valid(data_valid), .data_wr(data_wr), .data_type(data_type),
    .data_addr(data_addr), .data_value(data_value),
    .data_ready(data_ready), .data_res(data_res),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 8'h00;
  endfunction

  // Byte memory: commits writes and returns the byte for last cycle's address.
  always begin
    @(negedge clk);
    #3;
    if (mem_wr) begin
      mem_model[mem_a] = mem_dout;
      wr_count++;
    end
    mem_din = rd_byte(a_prev);
    a_prev  = mem_a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, output logic [31:0] res, output int lat);
    @(negedge clk); #1;
    if (v.is_inst) begin
      inst_addr  = v.addr;
      inst_valid = 1'b1;
    end else begin
      data_wr    = v.wr;
      data_type  = v.dtype;
      data_addr  = v.addr;
      data_value = v.value;
      data_valid = 1'b1;
    end
    lat = -1;
    res = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      if (v.is_inst ? inst_ready : data_ready) begin
        lat = c;
        res = v.is_inst ? inst_res : data_res;
        break;
      end
    end
    inst_valid = 1'b0;
    data_valid = 1'b0;
  endtask

  // Fetch 0x10 and load word 0x60 requested in the same cycle.
  task automatic contend(input string tag, input int exp_inst_lat, input int exp_data_lat);
    int li = -1;
    int ld = -1;
    inst_addr  = 32'h10;
    data_addr  = 32'h60;
    data_wr    = 1'b0;
    data_type  = 3'b010;
    inst_valid = 1'b1;
    data_valid = 1'b1;
    for (int c = 1; c <= 40 && (li < 0 || ld < 0); c++) begin
      @(negedge clk); #1;
      if (inst_ready && li < 0) begin
        li = c;
        check({tag, "_inst_res"}, inst_res, 32'h0000_0513);
        inst_valid = 1'b0;
      end
      if (data_ready && ld < 0) begin
        ld = c;
        check({tag, "_data_res"}, data_res, 32'hDEAD_BEEF);
        data_valid = 1'b0;
      end
    end
    inst_valid = 1'b0;
    data_valid = 1'b0;
    check({tag, "_inst_lat"}, 32'(li), 32'(exp_inst_lat));
    check({tag, "_data_lat"}, 32'(ld), 32'(exp_data_lat));
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          wr_base;

    mem_model[32'h10] = 8'h13; mem_model[32'h11] = 8'h05;
    mem_model[32'h12] = 8'h00; mem_model[32'h13] = 8'h00;
    mem_model[32'h20] = 8'h80; mem_model[32'h21] = 8'h7F;
    mem_model[32'h40] = 8'h93; mem_model[32'h41] = 8'h00;
    mem_model[32'h42] = 8'h10; mem_model[32'h43] = 8'h00;
    mem_model[32'h50] = 8'h34; mem_model[32'h51] = 8'hF2;
    mem_model[32'h60] = 8'hEF; mem_model[32'h61] = 8'hBE;
    mem_model[32'h62] = 8'hAD; mem_model[32'h63] = 8'hDE;
    mem_model[32'h102] = 8'h5A;

    vecs[0]  = '{"fetch",    1'b1, 1'b0, 3'b000, 32'h10,    32'h0,         32'h0000_0513, 6};
    vecs[1]  = '{"lb",       1'b0, 1'b0, 3'b000, 32'h20,    32'h0,         32'hFFFF_FF80, 3};
    vecs[2]  = '{"lbu",      1'b0, 1'b0, 3'b100, 32'h20,    32'h0,         32'h0000_0080, 3};
    vecs[3]  = '{"lb_pos",   1'b0, 1'b0, 3'b000, 32'h21,    32'h0,         32'h0000_007F, 3};
    vecs[4]  = '{"lh",       1'b0, 1'b0, 3'b001, 32'h50,    32'h0,         32'hFFFF_F234, 4};
    vecs[5]  = '{"lhu",      1'b0, 1'b0, 3'b101, 32'h50,    32'h0,         32'h0000_F234, 4};
    vecs[6]  = '{"lw",       1'b0, 1'b0, 3'b010, 32'h60,    32'h0,         32'hDEAD_BEEF, 6};
    vecs[7]  = '{"sh",       1'b0, 1'b1, 3'b001, 32'h100,   32'h1234_ABCD, 32'h0,         3};
    vecs[8]  = '{"sw",       1'b0, 1'b1, 3'b010, 32'h200,   32'hCAFE_F00D, 32'h0,         5};
    vecs[9]  = '{"lw_back",  1'b0, 1'b0, 3'b010, 32'h200,   32'h0,         32'hCAFE_F00D, 6};
    vecs[10] = '{"sb",       1'b0, 1'b1, 3'b000, 32'h210,   32'h0000_00A5, 32'h0,         2};
    vecs[11] = '{"lbu_back", 1'b0, 1'b0, 3'b100, 32'h210,   32'h0,         32'h0000_00A5, 3};

    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    inst_valid = 1'b0; inst_addr = '0;
    data_valid = 1'b0; data_wr = 1'b0; data_type = '0; data_addr = '0; data_value = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_inst_ready", 32'(inst_ready), 32'd0);
    check("rst_inst_res",   inst_res,        32'd0);
    check("rst_data_ready", 32'(data_ready), 32'd0);
    check("rst_data_res",   data_res,        32'd0);
    check("rst_mem_a",      mem_a,           32'd0);
    check("rst_mem_wr",     32'(mem_wr),     32'd0);
    check("rst_mem_dout",   32'(mem_dout),   32'd0);
    rst = 1'b0;

    // Contention straight out of reset: fetch wins, then the load.
    contend("rr_reset", 6, 12);

    // Word fetch with per-cycle address check.
    @(negedge clk); #1;
    inst_addr  = 32'h10;
    inst_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); #1;
      if (c <= 4) check("fetch_addr", mem_a, 32'h10 + 32'(c) - 32'd1);
      if (c == 5) check("fetch_rdy_early", 32'(inst_ready), 32'd0);
    end
    check("fetch_rdy", 32'(inst_ready), 32'd1);
    check("fetch_res", inst_res, 32'h0000_0513);
    inst_valid = 1'b0;

    // Last grant was the fetch, so the load now wins contention.
    @(negedge clk); #1;
    contend("rr_alt", 12, 6);

    wr_base = wr_count;
    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i], res, lat);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      if (!vecs[i].wr) check({vecs[i].name, "_res"}, res, vecs[i].exp_res);
    end
    check("sh_byte0",    32'(rd_byte(32'h100)), 32'h0000_00CD);
    check("sh_byte1",    32'(rd_byte(32'h101)), 32'h0000_00AB);
    check("sh_no_byte2", 32'(rd_byte(32'h102)), 32'h0000_005A);
    check("table_writes", 32'(wr_count - wr_base), 32'd7);

    // I/O store held off for three cycles by a full UART buffer.
    @(negedge clk); #1;
    io_buffer_full = 1'b1;
    data_wr = 1'b1; data_type = 3'b000; data_addr = 32'h0003_0000; data_value = 32'h0000_0041;
    data_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      check("io_stall_wr", 32'(mem_wr), 32'd0);
    end
    @(negedge clk); #1;
    io_buffer_full = 1'b0;
    #1;
    check("io_issue_wr",   32'(mem_wr),     32'd1);
    check("io_issue_a",    mem_a,           32'h0003_0000);
    check("io_issue_dout", 32'(mem_dout),   32'h0000_0041);
    check("io_rdy_early",  32'(data_ready), 32'd0);
    @(negedge clk); #1;
    check("io_rdy", 32'(data_ready), 32'd1);
    data_valid = 1'b0;
    check("io_mem", 32'(rd_byte(32'h0003_0000)), 32'h0000_0041);

    // Clear during a fetch aborts it; a new fetch follows in the next cycle.
    @(negedge clk); #1;
    inst_addr  = 32'h10;
    inst_valid = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    clear = 1'b1;
    @(negedge clk); #1;
    check("clr_fetch_bus", mem_a, 32'd0);
    check("clr_fetch_rdy", 32'(inst_ready), 32'd0);
    clear     = 1'b0;
    inst_addr = 32'h40;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      if (inst_ready) begin
        lat = c;
        check("refetch_res", inst_res, 32'h0010_0093);
        break;
      end
    end
    inst_valid = 1'b0;
    check("refetch_lat", 32'(lat), 32'd6);

    // Clear in IDLE blocks the grant for that edge only.
    @(negedge clk); #1;
    clear      = 1'b1;
    inst_addr  = 32'h10;
    inst_valid = 1'b1;
    @(negedge clk); #1;
    check("clr_idle_bus", mem_a, 32'd0);
    clear = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      if (inst_ready) begin
        lat = c;
        break;
      end
    end
    inst_valid = 1'b0;
    check("clr_idle_lat", 32'(lat), 32'd6);

    // Clear while a store is in flight does not stop it.
    @(negedge clk); #1;
    data_wr = 1'b1; data_type = 3'b010; data_addr = 32'h300; data_value = 32'h1122_3344;
    data_valid = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      if (c == 2) clear = 1'b1;
      if (c == 3) clear = 1'b0;
      if (data_ready) begin
        lat = c;
        break;
      end
    end
    clear      = 1'b0;
    data_valid = 1'b0;
    check("clr_wr_lat", 32'(lat), 32'd5);
    check("clr_wr_mem",
          {rd_byte(32'h303), rd_byte(32'h302), rd_byte(32'h301), rd_byte(32'h300)},
          32'h1122_3344);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
